// File: rtl/rng_pkg.sv
// ---------------------------------------------------------------------------
// rng_pkg -- shared definitions for the random-number server.
//   LFSR_TAPS    : feedback taps of the 32-bit right-shift Galois LFSR
//   DEFAULT_SEED : value loaded on reset and whenever a zero seed is written
//   state_t      : arbiter FSM states
//   lfsr_step()  : one Galois LFSR advance
// ---------------------------------------------------------------------------
package rng_pkg;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        GRANT   = 2'd2
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] value);
        logic [31:0] shifted;
        shifted = value >> 1;
        return value[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/rng_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- combinational round-robin priority picker.
//   req     : request vector
//   rr_ptr  : index with highest priority this round (must be < NUM_REQ)
//   winner  : first set bit of req found searching upward from rr_ptr, wrapping
//   any_req : high when at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0] pos;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        pos     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_req && req[pos[IDX_W-1:0]]) begin
                winner  = pos[IDX_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// ---------------------------------------------------------------------------
// rng_arbiter -- shares one 32-bit Galois LFSR among NUM_REQ requesters.
//   clk, reset_n : clock, synchronous active-low reset
//   seed         : seed word from the CPU; any change reseeds the LFSR
//   req          : per-requester request levels
//   gnt          : one-hot single-cycle grant pulse (registered)
//   rnd_data     : random word, valid while gnt is high, held otherwise
//   busy         : high while the FSM is in ADVANCE or GRANT
//   grant_count  : issued-grant counter, present only with RNG_GRANT_COUNT_EN
// Parameters: NUM_REQ (2..8), STEPS_PER_GRANT (1..16).
//
// Handshake: a requester raises req[i] and holds it until it sees gnt[i]
// for one cycle with rnd_data valid in that same cycle. It may withdraw req
// before that; a winner whose req is low in GRANT gets no pulse, and the
// LFSR steps already taken are not rolled back.
// ---------------------------------------------------------------------------
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int STEPS_PER_GRANT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        seed,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_data,
    output logic               busy
`ifdef RNG_GRANT_COUNT_EN
    ,
    output logic [15:0]        grant_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] GNT_LSB   = NUM_REQ'(1);
    localparam logic [4:0]         LAST_STEP = 5'(STEPS_PER_GRANT - 1);

    state_t           state;
    state_t           state_next;
    logic [31:0]      lfsr;
    logic [31:0]      seed_q;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] winner_q;
    logic [IDX_W-1:0] ptr_after;
    logic [4:0]       step_cnt;
    logic             any_req;
    logic             reseed;
    logic             latch_en;
    logic             step_en;
    logic             grant_en;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign reseed    = (seed != seed_q);
    assign ptr_after = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        step_en    = 1'b0;
        grant_en   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    latch_en   = 1'b1;
                    state_next = ADVANCE;
                end
            end
            ADVANCE: begin
                step_en = 1'b1;
                if (step_cnt == LAST_STEP) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // Only issue the pulse if the winner is still asking.
                grant_en   = req[winner_q];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            lfsr     <= DEFAULT_SEED;
            seed_q   <= '0;
            rr_ptr   <= '0;
            winner_q <= '0;
            step_cnt <= '0;
            gnt      <= '0;
            rnd_data <= '0;
`ifdef RNG_GRANT_COUNT_EN
            grant_count <= '0;
`endif
        end else begin
            seed_q <= seed;
            gnt    <= '0;
            if (reseed) begin
                // A new seed wins over any work in flight; rr_ptr survives.
                state    <= IDLE;
                lfsr     <= (seed == '0) ? DEFAULT_SEED : seed;
                step_cnt <= '0;
`ifdef RNG_GRANT_COUNT_EN
                grant_count <= '0;
`endif
            end else begin
                state <= state_next;
                if (latch_en) begin
                    winner_q <= winner;
                    step_cnt <= '0;
                end
                if (step_en) begin
                    lfsr     <= lfsr_step(lfsr);
                    step_cnt <= step_cnt + 5'd1;
                end
                if (grant_en) begin
                    gnt      <= GNT_LSB << winner_q;
                    rnd_data <= lfsr;
                    rr_ptr   <= ptr_after;
`ifdef RNG_GRANT_COUNT_EN
                    grant_count <= grant_count + 16'd1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rng_arbiter -- self-checking bench for rng_arbiter (NUM_REQ=4,
// STEPS_PER_GRANT=1). Inputs are driven and outputs sampled on the falling
// edge. The reference keeps the LFSR value, the round-robin pointer and an
// expected-data queue; grant_count checks exist only with RNG_GRANT_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_rng_arbiter;

    localparam int N        = 4;
    localparam int IW       = $clog2(N);
    localparam int STEPS    = 1;
    localparam int LAT      = STEPS + 2;   // falling edges from driving req to seeing gnt
    localparam int WAIT_MAX = 20;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   seed;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [31:0]   rnd_data;
    logic          busy;
`ifdef RNG_GRANT_COUNT_EN
    logic [15:0]   grant_count;
`endif

    always #5 clk = ~clk;

    rng_arbiter #(
        .NUM_REQ         (N),
        .STEPS_PER_GRANT (STEPS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .seed     (seed),
        .req      (req),
        .gnt      (gnt),
        .rnd_data (rnd_data),
        .busy     (busy)
`ifdef RNG_GRANT_COUNT_EN
        ,
        .grant_count (grant_count)
`endif
    );

    // ---------------- reference model / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_lfsr;
    int          m_ptr;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] model_step(input logic [31:0] x);
        if (x[0]) return (x >> 1) ^ TAPS;
        return x >> 1;
    endfunction

    function automatic logic [31:0] model_advance(input logic [31:0] x);
        logic [31:0] v;
        v = x;
        for (int k = 0; k < STEPS; k++) v = model_step(v);
        return v;
    endfunction

    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        int j;
        for (int i = 0; i < N; i++) begin
            j = (ptr + i) % N;
            if (r[j[IW-1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i[IW-1:0]] = 1'b1;
        return v;
    endfunction

    task automatic model_seed(input logic [31:0] v);
        m_lfsr = (v == 32'h0) ? 32'h1 : v;
    endtask

    // A completed grant: winner from the pointer, fresh LFSR value queued.
    task automatic model_grant(input logic [N-1:0] mask, output int idx);
        idx    = model_pick(mask, m_ptr);
        m_lfsr = model_advance(m_lfsr);
        exp_q.push_back(m_lfsr);
        m_ptr  = (idx + 1) % N;
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_seed(input logic [31:0] v);
        if (v != seed) model_seed(v);
        seed = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_grant(input logic [N-1:0] mask, output logic [N-1:0] g,
                             output logic [31:0] d, output int n, output logic b1);
        req = mask;
        @(negedge clk);
        n  = 1;
        b1 = busy;
        while (gnt == '0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        g   = gnt;
        d   = rnd_data;
        req = '0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [N-1:0] g; logic [31:0] d, e; int n, idx; logic b1;
        reset_n = 1'b0; req = '1; seed = '0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
        checks++; if (rnd_data !== 32'h0) begin errors++; $display("FAIL reset_rnd got %h want 0", rnd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset_n = 1'b1;
        model_seed(seed);
        m_ptr = 0;
        model_grant('1, idx);
        run_grant('1, g, d, n, b1);
        e = exp_q.pop_front();
        checks++; if (g !== onehot(idx)) begin errors++; $display("FAIL first_gnt got %b want %b", g, onehot(idx)); end
        checks++; if (d !== e) begin errors++; $display("FAIL first_rnd got %h want %h", d, e); end
        checks++; if (d !== 32'h8020_0003) begin errors++; $display("FAIL first_rnd_const got %h want 80200003", d); end
    endtask

    task automatic test_single();
        logic [N-1:0] g; logic [31:0] d, e; int n, idx; logic b1;
        logic [31:0] want [2];
        want[0] = 32'h8020_0003;
        want[1] = 32'hC030_0002;
        write_seed(32'h1);
        for (int k = 0; k < 2; k++) begin
            model_grant(4'b0001, idx);
            run_grant(4'b0001, g, d, n, b1);
            e = exp_q.pop_front();
            checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL single_busy[%0d] got %b want 1", k, b1); end
            checks++; if (n !== LAT) begin errors++; $display("FAIL single_latency[%0d] got %0d want %0d", k, n, LAT); end
            checks++; if (g !== onehot(idx)) begin errors++; $display("FAIL single_gnt[%0d] got %b want %b", k, g, onehot(idx)); end
            checks++; if (d !== e || d !== want[k]) begin errors++; $display("FAIL single_rnd[%0d] got %h want %h", k, d, want[k]); end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] seen[$]; logic [31:0] e; int n, idx;
        req = '1;
        for (int k = 0; k < 8; k++) begin
            model_grant('1, idx);
            n = 0;
            do begin @(negedge clk); n++; end while (gnt == '0 && n < WAIT_MAX);
            e = exp_q.pop_front();
            checks++; if (gnt !== onehot(idx)) begin errors++; $display("FAIL rr_order[%0d] got %b want %b", k, gnt, onehot(idx)); end
            checks++; if (rnd_data !== e) begin errors++; $display("FAIL rr_rnd[%0d] got %h want %h", k, rnd_data, e); end
            checks++; if (n !== LAT) begin errors++; $display("FAIL rr_spacing[%0d] got %0d want %0d", k, n, LAT); end
            foreach (seen[s]) begin
                checks++;
                if (seen[s] === rnd_data) begin errors++; $display("FAIL rr_distinct[%0d] got %h repeated want unique", k, rnd_data); end
            end
            seen.push_back(rnd_data);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] g, mask; logic [31:0] d, e, s; int n, idx; logic b1;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
                write_seed(s);
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            model_grant(mask, idx);
            run_grant(mask, g, d, n, b1);
            e = exp_q.pop_front();
            checks++; if (g !== onehot(idx)) begin errors++; $display("FAIL rand_gnt[%0d] mask %b got %b want %b", k, mask, g, onehot(idx)); end
            checks++; if (d !== e) begin errors++; $display("FAIL rand_rnd[%0d] got %h want %h", k, d, e); end
        end
    endtask

    task automatic test_reseed_midflight();
        logic [31:0] e; int n, idx;
        write_seed(32'h1);
        req = 4'b0001;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reseed_busy_before got %b want 1", busy); end
        seed = 32'hDEAD_BEEF;
        model_seed(32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reseed_busy_after got %b want 0", busy); end
        checks++; if (gnt !== '0) begin errors++; $display("FAIL reseed_no_gnt got %b want 0", gnt); end
`ifdef RNG_GRANT_COUNT_EN
        checks++; if (grant_count !== 16'd0) begin errors++; $display("FAIL reseed_count got %0d want 0", grant_count); end
`endif
        model_grant(4'b0001, idx);
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == '0 && n < WAIT_MAX);
        e = exp_q.pop_front();
        checks++; if (n !== LAT) begin errors++; $display("FAIL reseed_latency got %0d want %0d", n, LAT); end
        checks++; if (gnt !== onehot(idx)) begin errors++; $display("FAIL reseed_gnt got %b want %b", gnt, onehot(idx)); end
        checks++; if (rnd_data !== e) begin errors++; $display("FAIL reseed_rnd got %h want %h", rnd_data, e); end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_seed_zero();
        logic [N-1:0] g; logic [31:0] d, e; int n, idx; logic b1;
        write_seed(32'h0);
        model_grant(4'b0010, idx);
        run_grant(4'b0010, g, d, n, b1);
        e = exp_q.pop_front();
        checks++; if (g !== onehot(idx)) begin errors++; $display("FAIL zero_gnt got %b want %b", g, onehot(idx)); end
        checks++; if (d !== e || d !== 32'h8020_0003) begin errors++; $display("FAIL zero_rnd got %h want 80200003", d); end
    endtask

    task automatic test_withdraw();
        logic [N-1:0] g; logic [31:0] d, e; int n, idx; logic b1;
`ifdef RNG_GRANT_COUNT_EN
        logic [15:0] cnt_before;
`endif
        // Park the pointer at 1 so a pointer move is visible afterwards.
        model_grant(4'b0001, idx);
        run_grant(4'b0001, g, d, n, b1);
        e = exp_q.pop_front();
        checks++; if (g !== onehot(idx) || d !== e) begin errors++; $display("FAIL wd_setup got %b/%h want %b/%h", g, d, onehot(idx), e); end
`ifdef RNG_GRANT_COUNT_EN
        cnt_before = grant_count;
`endif
        req = 4'b0100;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_busy got %b want 1", busy); end
        req = '0;
        m_lfsr = model_advance(m_lfsr);   // steps happen, no grant, pointer stays
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (gnt !== '0) begin errors++; $display("FAIL wd_no_gnt[%0d] got %b want 0", k, gnt); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle got %b want 0", busy); end
`ifdef RNG_GRANT_COUNT_EN
        checks++; if (grant_count !== cnt_before) begin errors++; $display("FAIL wd_count got %0d want %0d", grant_count, cnt_before); end
`endif
        model_grant('1, idx);
        run_grant('1, g, d, n, b1);
        e = exp_q.pop_front();
        checks++; if (g !== onehot(idx)) begin errors++; $display("FAIL wd_ptr_kept got %b want %b", g, onehot(idx)); end
        checks++; if (d !== e) begin errors++; $display("FAIL wd_twice_stepped got %h want %h", d, e); end
`ifdef RNG_GRANT_COUNT_EN
        checks++; if (grant_count !== cnt_before + 16'd1) begin errors++; $display("FAIL wd_count_next got %0d want %0d", grant_count, cnt_before + 16'd1); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g; logic [31:0] d, e; int n, idx; logic b1;
        req = 4'b0001;
        @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (gnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d] got gnt %b busy %b want 0 0", k, gnt, busy); end
        end
        checks++; if (rnd_data !== 32'h0) begin errors++; $display("FAIL rstmid_rnd got %h want 0", rnd_data); end
        reset_n = 1'b1;
        model_seed(seed);
        m_ptr = 0;
        @(negedge clk);
        model_grant('1, idx);
        run_grant('1, g, d, n, b1);
        e = exp_q.pop_front();
        checks++; if (g !== onehot(idx)) begin errors++; $display("FAIL rstmid_gnt got %b want %b", g, onehot(idx)); end
        checks++; if (d !== e) begin errors++; $display("FAIL rstmid_rnd_next got %h want %h", d, e); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_reseed_midflight();
        test_seed_zero();
        test_withdraw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Hardware random-number server for the game datapath.
- Takes the 32-bit seed word that the CPU writes through the random_number PIO out_port, and runs a 32-bit Galois LFSR from it.
- Shares that generator among NUM_REQ requesters (meteorite spawners, trajectory/speed pickers) with round-robin arbitration.
- Every grant delivers a freshly advanced value, so no two requesters ever receive the same word.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- STEPS_PER_GRANT, 1, LFSR advances per grant; legal range 1..16, for decorrelation.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- seed  in  32  seed word, driven from the PIO out_port.
- req  in  NUM_REQ  per-requester request level; held until the matching gnt or withdrawn.
- gnt  out  NUM_REQ  one-hot, single-cycle grant pulse; registered.
- rnd_data  out  32  random word; valid in the cycle gnt is high, holds its value otherwise; registered.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, lfsr=DEFAULT_SEED (32'h0000_0001), seed_q=0, rr_ptr=0, step_cnt=0.
  - Outputs: gnt=0, rnd_data=0, busy=0.
- Reset mid-operation aborts any grant in flight; no gnt is issued.
- Reseed:
  - seed_q registers seed every cycle.
  - If seed != seed_q, the next edge loads lfsr with seed, or with DEFAULT_SEED when seed==0 (the LFSR must never be all-zero).
  - Reseed forces state=IDLE, abandons any in-flight grant (no gnt), and has priority over everything except reset.
  - rr_ptr is kept across a reseed.
- LFSR step (right-shift Galois, taps LFSR_TAPS=32'h8020_0003):
  - b=lfsr[0]; lfsr=lfsr>>1; if b, then lfsr^=LFSR_TAPS.
  - lfsr steps only in ADVANCE.
- FSM:
  - IDLE: if req!=0, latch the winner = first set bit of req searching from rr_ptr upward with wrap; step_cnt=0; go to ADVANCE.
  - ADVANCE: step lfsr once per cycle; step_cnt++; after STEPS_PER_GRANT steps go to GRANT.
  - GRANT: if req[winner] is still high, then gnt[winner]=1, rnd_data=lfsr, rr_ptr=(winner+1) mod NUM_REQ. Otherwise (withdrawn) no gnt and rr_ptr is unchanged; the LFSR advance is not undone. Next state IDLE in both cases.
- Latency: req seen in IDLE at edge t → gnt high in cycle t+STEPS_PER_GRANT+1.
  - Back-to-back throughput: one grant per STEPS_PER_GRANT+2 cycles.
- Simultaneous requests are served in strict round-robin order.
  - A requester whose req stays high is served again no sooner than after every other active requester.
- req changes during ADVANCE do not alter the latched winner.
- busy is high in ADVANCE and GRANT.

Optional Feature:
- Macro RNG_GRANT_COUNT_EN.
- Defined: adds output grant_count[15:0].
  - Reset to 0; increments by 1 on every issued gnt, wrapping from 16'hFFFF to 0.
  - Cleared on reseed.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package rng_pkg: LFSR_TAPS, DEFAULT_SEED, a state enum {IDLE, ADVANCE, GRANT}, and a function lfsr_step(logic [31:0]).
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req, rr_ptr. Outputs: winner index and any_req.
  - Reusable by other arbiters in the platform.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with req=4'b1111 → gnt=0, rnd_data=0, busy=0. Release with seed=0 → first grant to req[0] has rnd_data=32'h8020_0003.
- Seed=32'h1, STEPS=1, single req[0] pulse held → gnt[0] exactly 2 cycles after the IDLE sample, rnd_data=32'h8020_0003. Repeat → 32'hC030_0002.
- req=4'b1111 held continuously → grant order 0,1,2,3,0. Each rnd_data is distinct and matches the reference-model LFSR sequence. Grants are spaced 3 cycles apart.
- Seed change (32'h1 → 32'hDEAD_BEEF) during ADVANCE → no gnt for the in-flight winner, busy drops, and the next grant returns lfsr_step(32'hDEAD_BEEF).
- Write seed=0 → lfsr loads 32'h1 (not zero); the next grant returns 32'h8020_0003.
- req[2] dropped during ADVANCE → no gnt in GRANT, rr_ptr unchanged, and the next req[2] grant returns the twice-stepped value. With RNG_GRANT_COUNT_EN, grant_count does not increment.
